kgp_risc_trace_buf: RTL and testbench

- Parametrised register-trace unit, the successor to the single 16-bit observation port on the KGP_RISC top level.
- Samples one of NUM_CH processor-visible values, e.g. routa and other register taps, under one of three capture modes.
- Stamps each sample with a cycle count and buffers it in a DEPTH-entry FIFO.
- The FIFO is drained through a valid/ready port by a bench or debug host.

---
 rtl/kgp_risc_trace_buf.sv | 210 +++++++++++++++++++++
 tb/tb_kgp_risc_trace_buf.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/kgp_risc_trace_buf.sv
// Register-trace unit: samples one selected channel under a capture mode,
// stamps it with a free-running cycle count and queues it in a drainable FIFO.
module kgp_risc_trace_buf #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    input  logic                      trig,
    input  logic                      clr,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_W-1:0]         rd_data,
    output logic [TS_W-1:0]           rd_ts,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      done
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0]       MODE_OFF  = 2'b00;
    localparam logic [1:0]       MODE_EVERY = 2'b01;
    localparam logic [1:0]       MODE_TRIG = 2'b11;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TS_W-1:0]  TS_ONE    = {{(TS_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_ARMED = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [1:0]              mode_r;
    logic [CH_W-1:0]         ch_sel_r;
    logic                    first_r;
    logic [DATA_W-1:0]       ref_r;
    logic [CNT_W-1:0]        fill_cnt_r;
    logic                    done_r;
    logic [TS_W-1:0]         ts_r;
    logic                    sample_s;
    logic                    latch_s;
    logic [DATA_W-1:0]       sel_data_s;

    logic [TS_W+DATA_W-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic                    rd_valid_r;
    logic [DATA_W-1:0]       rd_data_r;
    logic [TS_W-1:0]         rd_ts_r;
    logic                    overflow_r;
    logic                    pop_s;
    logic                    push_req_s;
    logic                    push_ok_s;
    logic                    drop_s;
    logic [PTR_W-1:0]        head_idx_s;
    logic [CNT_W-1:0]        remain_s;

    assign sel_data_s = ch_data[int'(ch_sel_r)*DATA_W +: DATA_W];

    // Next-state and sample decision for the capture FSM
    always_comb begin
        state_next_s = state_r;
        sample_s     = 1'b0;
        latch_s      = 1'b0;
        if (!enable) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mode != MODE_OFF) begin
                        latch_s      = 1'b1;
                        state_next_s = (mode == MODE_TRIG) ? ST_ARMED : ST_RUN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (mode_r == MODE_EVERY) begin
                        sample_s = 1'b1;
                    end else begin
                        // on-change: the first RUN cycle always records a baseline
                        sample_s = first_r || (sel_data_s != ref_r);
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        sample_s     = 1'b1;
                        state_next_s = ST_FILL;
                    end else begin
                        state_next_s = ST_ARMED;
                    end
                end
                ST_FILL: begin
                    sample_s = 1'b1;
                    if (fill_cnt_r == DEPTH_C - CNT_ONE) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end
                ST_DONE: state_next_s = ST_DONE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Capture control state, latched configuration and timestamp counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_OFF;
            ch_sel_r   <= {CH_W{1'b0}};
            first_r    <= 1'b0;
            ref_r      <= {DATA_W{1'b0}};
            fill_cnt_r <= {CNT_W{1'b0}};
            done_r     <= 1'b0;
            ts_r       <= {TS_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            ts_r    <= ts_r + TS_ONE;
            if (latch_s) begin
                mode_r   <= mode;
                ch_sel_r <= ch_sel;
            end
            first_r <= latch_s && (mode != MODE_TRIG);
            if (sample_s) begin
                ref_r <= sel_data_s;
            end
            // dropped samples still advance the one-shot fill count
            if (sample_s && (state_r == ST_ARMED)) begin
                fill_cnt_r <= CNT_ONE;
            end else if (sample_s && (state_r == ST_FILL)) begin
                fill_cnt_r <= fill_cnt_r + CNT_ONE;
            end
            done_r <= (state_next_s == ST_DONE);
        end
    end

    // FIFO handshake terms and the entry that will sit at the head next cycle
    always_comb begin
        pop_s      = rd_valid_r && rd_ready;
        push_req_s = sample_s && !clr;
        push_ok_s  = push_req_s && ((count_r < DEPTH_C) || pop_s);
        drop_s     = push_req_s && !push_ok_s;
        head_idx_s = rd_ptr_r + PTR_W'(pop_s);
        remain_s   = count_r - CNT_W'(pop_s);
    end

    // Sample storage; no reset needed since occupancy qualifies every read
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= {ts_r, sel_data_s};
        end
    end

    // FIFO pointers, occupancy, overflow and registered head outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_W{1'b0}};
            rd_ts_r    <= {TS_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (clr) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            rd_valid_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_r + PTR_W'(push_ok_s);
            rd_ptr_r   <= head_idx_s;
            count_r    <= remain_s + CNT_W'(push_ok_s);
            overflow_r <= overflow_r || drop_s;
            rd_valid_r <= (remain_s != {CNT_W{1'b0}}) || push_ok_s;
            // an empty FIFO forwards the new sample straight to the head
            if (remain_s != {CNT_W{1'b0}}) begin
                {rd_ts_r, rd_data_r} <= mem_r[head_idx_s];
            end else if (push_ok_s) begin
                rd_data_r <= sel_data_s;
                rd_ts_r   <= ts_r;
            end
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign rd_ts    = rd_ts_r;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign done     = done_r;

endmodule

// File: tb/tb_kgp_risc_trace_buf.sv
// Directed bench for kgp_risc_trace_buf: capture modes, FIFO full/wrap,
// clear and mid-capture reset, with hand-computed expectations.
module tb_kgp_risc_trace_buf;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [1:0]  ch_sel;
    logic [63:0] ch_data;
    logic        trig;
    logic        clr;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [15:0] rd_ts;
    logic [4:0]  count;
    logic        overflow;
    logic        done;

    int          checks;
    int          failures;
    logic [15:0] ts_m;
    logic [15:0] ts_e;
    logic [15:0] exp_ts;

    kgp_risc_trace_buf #(
        .DATA_W(16), .NUM_CH(4), .DEPTH(16), .TS_W(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .ch_sel(ch_sel), .ch_data(ch_data), .trig(trig), .clr(clr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_ts(rd_ts), .count(count), .overflow(overflow), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock; ts_m mirrors the free-running timestamp of the new cycle
    task automatic step();
        if (reset) ts_m = ts_m + 16'd1;
        else       ts_m = 16'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [15:0] v);
        ch_data[k*16 +: 16] = v;
    endtask

    initial begin
        checks = 0; failures = 0; ts_m = 16'd0;
        reset = 1'b0; enable = 1'b0; mode = 2'b00; ch_sel = 2'd0;
        ch_data = 64'd0; trig = 1'b0; clr = 1'b0; rd_ready = 1'b0;
        step(); step();
        reset = 1'b1;

        check_eq("rst_valid", rd_valid, 1'b0);
        check_eq("rst_count", count, 5'd0);
        check_eq("rst_data", rd_data, 16'h0000);
        check_eq("rst_ts", rd_ts, 16'h0000);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_done", done, 1'b0);

        // 1: every-cycle capture with a draining consumer
        mode = 2'b01; ch_sel = 2'd1; enable = 1'b1; rd_ready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            set_ch(1, 16'h0010 + 16'(i));
            exp_ts = ts_m;
            step();
            check_eq("t1_valid", rd_valid, 1'b1);
            check_eq("t1_data", rd_data, 16'h0010 + 16'(i));
            check_eq("t1_ts", rd_ts, exp_ts);
        end
        enable = 1'b0;
        step();
        check_eq("t1_empty_valid", rd_valid, 1'b0);
        check_eq("t1_empty_count", count, 5'd0);
        check_eq("t1_hold_data", rd_data, 16'h0014);
        check_eq("t1_ovf", overflow, 1'b0);

        // 2: on-change capture
        mode = 2'b10; ch_sel = 2'd0; rd_ready = 1'b0; set_ch(0, 16'hAAAA);
        enable = 1'b1;
        step();
        repeat (4) step();
        set_ch(0, 16'h5555);
        repeat (3) step();
        set_ch(0, 16'hAAAA);
        step();
        enable = 1'b0;
        step();
        check_eq("t2_count", count, 5'd3);
        check_eq("t2_e0", rd_data, 16'hAAAA);
        rd_ready = 1'b1;
        step();
        check_eq("t2_e1", rd_data, 16'h5555);
        step();
        check_eq("t2_e2", rd_data, 16'hAAAA);
        step();
        check_eq("t2_drained", rd_valid, 1'b0);
        rd_ready = 1'b0;

        // 3: triggered one-shot, trigger 7 cycles after the enable edge
        mode = 2'b11; ch_sel = 2'd2; set_ch(2, 16'h1234);
        enable = 1'b1; ts_e = ts_m;
        step();
        repeat (6) step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        check_eq("t3_first_count", count, 5'd1);
        check_eq("t3_first_ts", rd_ts, ts_e + 16'd7);
        check_eq("t3_first_data", rd_data, 16'h1234);
        repeat (14) step();
        check_eq("t3_count15", count, 5'd15);
        check_eq("t3_not_done", done, 1'b0);
        step();
        check_eq("t3_count16", count, 5'd16);
        check_eq("t3_done", done, 1'b1);
        repeat (3) step();
        check_eq("t3_no_more", count, 5'd16);
        check_eq("t3_ovf", overflow, 1'b0);
        check_eq("t3_done_hold", done, 1'b1);
        check_eq("t3_head_ts", rd_ts, ts_e + 16'd7);
        enable = 1'b0;
        step();
        check_eq("t3_done_clr", done, 1'b0);
        check_eq("t3_retained", count, 5'd16);

        // 4: overflow under back-pressure, then clear
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("t4_pre_clr", count, 5'd0);
        mode = 2'b01; ch_sel = 2'd0; enable = 1'b1;
        step();
        repeat (20) step();
        check_eq("t4_full", count, 5'd16);
        check_eq("t4_ovf", overflow, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("t4_clr_count", count, 5'd0);
        check_eq("t4_clr_ovf", overflow, 1'b0);
        check_eq("t4_clr_valid", rd_valid, 1'b0);
        step();
        check_eq("t4_still_run", count, 5'd1);

        // 5: full FIFO with a ready consumer, across pointer wrap
        enable = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        mode = 2'b01; ch_sel = 2'd3; enable = 1'b1;
        step();
        for (int n = 1; n <= 40; n++) begin
            set_ch(3, 16'h3000 + 16'(n - 1));
            rd_ready = (n >= 17);
            if (n >= 17) begin
                check_eq("t5_order", rd_data, 16'h3000 + 16'(n - 17));
                check_eq("t5_count", count, 5'd16);
            end
            step();
        end
        check_eq("t5_ovf", overflow, 1'b0);
        enable = 1'b0; rd_ready = 1'b0;
        step();

        // 6: reset in the middle of a one-shot fill
        clr = 1'b1;
        step();
        clr = 1'b0;
        mode = 2'b11; ch_sel = 2'd0; set_ch(0, 16'h0606); enable = 1'b1;
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (8) step();
        check_eq("t6_count9", count, 5'd9);
        reset = 1'b0;
        step();
        check_eq("t6_count", count, 5'd0);
        check_eq("t6_valid", rd_valid, 1'b0);
        check_eq("t6_done", done, 1'b0);
        check_eq("t6_data", rd_data, 16'h0000);
        reset = 1'b1; mode = 2'b01;
        step();
        check_eq("t6_idle", count, 5'd0);
        step();
        check_eq("t6_run_valid", rd_valid, 1'b1);
        check_eq("t6_ts_restart", rd_ts, 16'd1);
        check_eq("t6_run_data", rd_data, 16'h0606);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
